// File: rtl/ifft8_pkg.sv
// Shared types and constants for the 8-point sequential inverse FFT.
package ifft8_pkg;

    localparam int DW      = 32;
    localparam int TW      = 16;
    localparam int TW_FRAC = 14;

    // Twiddle ROM, W^m = e^{+j2*pi*m/8} in signed Q1.14
    localparam logic signed [TW-1:0] W0_RE = 16'sd16384;
    localparam logic signed [TW-1:0] W0_IM = 16'sd0;
    localparam logic signed [TW-1:0] W1_RE = 16'sd11585;
    localparam logic signed [TW-1:0] W1_IM = 16'sd11585;
    localparam logic signed [TW-1:0] W2_RE = 16'sd0;
    localparam logic signed [TW-1:0] W2_IM = 16'sd16384;
    localparam logic signed [TW-1:0] W3_RE = -16'sd11585;
    localparam logic signed [TW-1:0] W3_IM = 16'sd11585;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    function automatic logic signed [TW-1:0] twiddleRe(input logic [1:0] m);
        case (m)
            2'd0:    return W0_RE;
            2'd1:    return W1_RE;
            2'd2:    return W2_RE;
            default: return W3_RE;
        endcase
    endfunction

    function automatic logic signed [TW-1:0] twiddleIm(input logic [1:0] m);
        case (m)
            2'd0:    return W0_IM;
            2'd1:    return W1_IM;
            2'd2:    return W2_IM;
            default: return W3_IM;
        endcase
    endfunction

endpackage

// File: rtl/cplx_bfly_dif.sv
// Combinational radix-2 decimation-in-frequency butterfly:
// a' = a + b, b' = ((a - b) * W) >>> 14, all sums wrapping modulo 2^DW.
module cplx_bfly_dif
    import ifft8_pkg::*;
(
    input  logic signed [DW-1:0] a_re_i,
    input  logic signed [DW-1:0] a_im_i,
    input  logic signed [DW-1:0] b_re_i,
    input  logic signed [DW-1:0] b_im_i,
    input  logic signed [TW-1:0] w_re_i,
    input  logic signed [TW-1:0] w_im_i,
    output logic signed [DW-1:0] a_re_o,
    output logic signed [DW-1:0] a_im_o,
    output logic signed [DW-1:0] b_re_o,
    output logic signed [DW-1:0] b_im_o
);

    // Wide enough to hold the difference of two DW x TW products without overflow.
    localparam int PW = DW + TW + 1;

    logic signed [DW-1:0] diffRe;
    logic signed [DW-1:0] diffIm;
    logic signed [PW-1:0] prodRe;
    logic signed [PW-1:0] prodIm;

    // Sum/difference wrap at DW; the twiddle product is kept at full precision, floored, then truncated.
    always_comb begin
        a_re_o = a_re_i + b_re_i;
        a_im_o = a_im_i + b_im_i;
        diffRe = a_re_i - b_re_i;
        diffIm = a_im_i - b_im_i;
        prodRe = PW'(diffRe) * PW'(w_re_i) - PW'(diffIm) * PW'(w_im_i);
        prodIm = PW'(diffRe) * PW'(w_im_i) + PW'(diffIm) * PW'(w_re_i);
        b_re_o = DW'(prodRe >>> TW_FRAC);
        b_im_o = DW'(prodIm >>> TW_FRAC);
    end

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point inverse FFT: load 8 bins, run 12 in-place DIF butterflies,
// stream 8 time samples out in natural order scaled by 1/8.
module ifft8_seq
    import ifft8_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          busy
);

    state_e               state_q;
    logic [2:0]           loadCnt_q;
    logic [3:0]           bflyCnt_q;
    logic [2:0]           outCnt_q;
    logic                 inReady_q;
    logic                 outValid_q;
    logic                 outLast_q;
    logic                 busy_q;
    logic signed [DW-1:0] outRe_q;
    logic signed [DW-1:0] outIm_q;

    logic signed [DW-1:0] ramRe_q [8];
    logic signed [DW-1:0] ramIm_q [8];

    logic [2:0]           idxA_d;
    logic [2:0]           idxB_d;
    logic [1:0]           twIdx_d;
    logic [2:0]           rdIdx_d;
    logic signed [DW-1:0] rdRe_d;
    logic signed [DW-1:0] rdIm_d;
    logic                 loadFire;

    logic signed [DW-1:0] bfARe;
    logic signed [DW-1:0] bfAIm;
    logic signed [DW-1:0] bfBRe;
    logic signed [DW-1:0] bfBIm;

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign busy      = busy_q;
    assign out_re    = outRe_q;
    assign out_im    = outIm_q;
    assign loadFire  = (state_q == LOAD) && in_valid && inReady_q;

    // Map the butterfly counter (stage in [3:2], butterfly in [1:0]) to the pair (i, i+h) and twiddle index m.
    always_comb begin
        idxA_d  = '0;
        idxB_d  = '0;
        twIdx_d = '0;
        case (bflyCnt_q[3:2])
            2'd0: begin
                idxA_d  = {1'b0, bflyCnt_q[1:0]};
                idxB_d  = {1'b1, bflyCnt_q[1:0]};
                twIdx_d = bflyCnt_q[1:0];
            end
            2'd1: begin
                idxA_d  = {bflyCnt_q[1], 1'b0, bflyCnt_q[0]};
                idxB_d  = {bflyCnt_q[1], 1'b1, bflyCnt_q[0]};
                twIdx_d = {bflyCnt_q[0], 1'b0};
            end
            default: begin
                idxA_d  = {bflyCnt_q[1:0], 1'b0};
                idxB_d  = {bflyCnt_q[1:0], 1'b1};
                twIdx_d = 2'd0;
            end
        endcase
    end

    // Select the next output sample from the bit-reversed RAM and apply the 1/8 scale.
    always_comb begin
        rdIdx_d = bitrev3((state_q == OUTPUT) ? (outCnt_q + 3'd1) : 3'd0);
        rdRe_d  = ramRe_q[rdIdx_d] >>> 3;
        rdIm_d  = ramIm_q[rdIdx_d] >>> 3;
    end

    cplx_bfly_dif u_bfly (
        .a_re_i (ramRe_q[idxA_d]),
        .a_im_i (ramIm_q[idxA_d]),
        .b_re_i (ramRe_q[idxB_d]),
        .b_im_i (ramIm_q[idxB_d]),
        .w_re_i (twiddleRe(twIdx_d)),
        .w_im_i (twiddleIm(twIdx_d)),
        .a_re_o (bfARe),
        .a_im_o (bfAIm),
        .b_re_o (bfBRe),
        .b_im_o (bfBIm)
    );

    // Working RAM: bins land here during LOAD, butterflies overwrite their pair in place during COMPUTE.
    always_ff @(posedge clk) begin
        if (loadFire) begin
            ramRe_q[loadCnt_q] <= in_re;
            ramIm_q[loadCnt_q] <= in_im;
        end else if (state_q == COMPUTE) begin
            ramRe_q[idxA_d] <= bfARe;
            ramIm_q[idxA_d] <= bfAIm;
            ramRe_q[idxB_d] <= bfBRe;
            ramIm_q[idxB_d] <= bfBIm;
        end
    end

    // Frame sequencing with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            loadCnt_q  <= '0;
            bflyCnt_q  <= '0;
            outCnt_q   <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            busy_q     <= 1'b0;
            outRe_q    <= '0;
            outIm_q    <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (loadFire) begin
                        loadCnt_q <= loadCnt_q + 3'd1;
                        if (loadCnt_q == 3'd7) begin
                            state_q   <= COMPUTE;
                            inReady_q <= 1'b0;
                            busy_q    <= 1'b1;
                            bflyCnt_q <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    bflyCnt_q <= bflyCnt_q + 4'd1;
                    if (bflyCnt_q == 4'd11) begin
                        state_q    <= OUTPUT;
                        outCnt_q   <= '0;
                        outValid_q <= 1'b1;
                        outLast_q  <= 1'b0;
                        outRe_q    <= rdRe_d;
                        outIm_q    <= rdIm_d;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (outCnt_q == 3'd7) begin
                            state_q    <= LOAD;
                            loadCnt_q  <= '0;
                            outValid_q <= 1'b0;
                            outLast_q  <= 1'b0;
                            inReady_q  <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            outCnt_q  <= outCnt_q + 3'd1;
                            outLast_q <= (outCnt_q == 3'd6);
                            outRe_q   <= rdRe_d;
                            outIm_q   <= rdIm_d;
                        end
                    end
                end
                default: begin
                    state_q   <= LOAD;
                    inReady_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft8_seq.sv
// Self-checking bench for ifft8_seq: directed frames with known answers plus
// random frames against an array-based inverse FFT reference.
module tb_ifft8_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_re;
    logic signed [31:0] in_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_re;
    logic signed [31:0] out_im;
    logic               out_last;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cycCount = 0;
    int lastInCycle = 0;

    int frameRe [8];
    int frameIm [8];
    int expRe   [8];
    int expIm   [8];
    int gotRe   [8];
    int gotIm   [8];

    int twRe [4] = '{16384, 11585, 0, -11585};
    int twIm [4] = '{0, 11585, 16384, 11585};

    ifft8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Free-running clock and cycle index used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    task automatic checkOutput(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap32(input longint v);
        return longint'(int'(v));
    endfunction

    // Reference: radix-2 DIF over a plain array, then bit-reversed read-out scaled by 1/8.
    function automatic void computeModel();
        longint vr [8];
        longint vi [8];
        int h;
        for (int k = 0; k < 8; k++) begin
            vr[k] = frameRe[k];
            vi[k] = frameIm[k];
        end
        h = 4;
        for (int s = 0; s < 3; s++) begin
            for (int base = 0; base < 8; base += 2 * h) begin
                for (int t = 0; t < h; t++) begin
                    int i;
                    int j;
                    int m;
                    longint dr;
                    longint di;
                    i = base + t;
                    j = i + h;
                    m = t << s;
                    dr = wrap32(vr[i] - vr[j]);
                    di = wrap32(vi[i] - vi[j]);
                    vr[i] = wrap32(vr[i] + vr[j]);
                    vi[i] = wrap32(vi[i] + vi[j]);
                    vr[j] = wrap32((dr * twRe[m] - di * twIm[m]) >>> 14);
                    vi[j] = wrap32((dr * twIm[m] + di * twRe[m]) >>> 14);
                end
            end
            h = h / 2;
        end
        for (int n = 0; n < 8; n++) begin
            int br;
            br = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            expRe[n] = int'(vr[br]) >>> 3;
            expIm[n] = int'(vi[br]) >>> 3;
        end
    endfunction

    // Feed the current frame with random gaps; optionally keep in_valid high with junk during COMPUTE.
    task automatic applyStimulus(input int gapPct, input bit junk);
        int k = 0;
        int guard = 0;
        while (k < 8 && guard < 300) begin
            in_valid = ($urandom_range(99) >= gapPct);
            in_re = in_valid ? frameRe[k] : $urandom;
            in_im = in_valid ? frameIm[k] : $urandom;
            #1;
            if (in_valid && in_ready) begin
                if (k == 7) lastInCycle = cycCount;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (k < 8) checkOutput("load_timeout", k, 8);
        if (junk) begin
            for (int c = 0; c < 6; c++) begin
                in_valid = 1'b1;
                in_re = $urandom;
                in_im = $urandom;
                #1;
                if (c == 2) begin
                    checkOutput("in_ready_compute", in_ready, 0);
                    checkOutput("busy_compute", busy, 1);
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
    endtask

    // Drain eight samples under the chosen out_ready pattern; abortAt < 8 pulls reset before that sample.
    task automatic collectFrame(input int stallMode, input int abortAt);
        int n = 0;
        int guard = 0;
        int p = 0;
        bit seen = 0;
        bit prevStall = 0;
        logic signed [31:0] hRe = 0;
        logic signed [31:0] hIm = 0;
        logic hLast = 0;
        while (n < 8 && guard < 400) begin
            case (stallMode)
                0:       out_ready = 1'b1;
                1:       out_ready = (p % 3 == 0);
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            if (out_valid) begin
                if (n == abortAt) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("abort_out_valid", out_valid, 0);
                    checkOutput("abort_in_ready", in_ready, 1);
                    checkOutput("abort_busy", busy, 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    out_ready = 1'b0;
                    return;
                end
                if (!seen) begin
                    seen = 1;
                    checkOutput("latency", cycCount - lastInCycle, 13);
                end
                if (prevStall) begin
                    checkOutput("hold_re", out_re, hRe);
                    checkOutput("hold_im", out_im, hIm);
                    checkOutput("hold_last", out_last, hLast);
                end
                checkOutput("in_ready_output", in_ready, 0);
                if (out_ready) begin
                    checkOutput($sformatf("re[%0d]", n), out_re, expRe[n]);
                    checkOutput($sformatf("im[%0d]", n), out_im, expIm[n]);
                    checkOutput($sformatf("last[%0d]", n), out_last, (n == 7) ? 1 : 0);
                    gotRe[n] = out_re;
                    gotIm[n] = out_im;
                    n++;
                    prevStall = 0;
                end else begin
                    prevStall = 1;
                    hRe = out_re;
                    hIm = out_im;
                    hLast = out_last;
                end
            end
            p++;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (n < 8) begin
            checkOutput("out_timeout", n, 8);
        end else begin
            #1;
            checkOutput("post_in_ready", in_ready, 1);
            checkOutput("post_out_valid", out_valid, 0);
        end
    endtask

    task automatic runFrame(input int gapPct, input bit junk, input int stallMode, input int abortAt);
        computeModel();
        applyStimulus(gapPct, junk);
        collectFrame(stallMode, abortAt);
    endtask

    task automatic setDcFrame();
        for (int k = 0; k < 8; k++) begin
            frameRe[k] = (k == 0) ? 8 : 0;
            frameIm[k] = 0;
        end
    endtask

    initial begin
        int toneIdx [6] = '{0, 1, 2, 4, 6, 7};
        int toneRe  [6] = '{1024, 724, 0, -1024, 0, 724};
        int toneIm  [6] = '{0, 724, 1024, 0, -1024, -724};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_re = 0;
        in_im = 0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_re", out_re, 0);
        checkOutput("reset_out_im", out_im, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] DC bin frame");
        setDcFrame();
        runFrame(0, 0, 0, 8);
        for (int n = 0; n < 8; n++) begin
            checkOutput($sformatf("dc_re[%0d]", n), gotRe[n], 1);
            checkOutput($sformatf("dc_im[%0d]", n), gotIm[n], 0);
        end

        $display("[TB] flat spectrum frame");
        for (int k = 0; k < 8; k++) begin
            frameRe[k] = 8;
            frameIm[k] = 0;
        end
        runFrame(0, 0, 0, 8);
        for (int n = 0; n < 8; n++) begin
            checkOutput($sformatf("flat_re[%0d]", n), gotRe[n], (n == 0) ? 8 : 0);
            checkOutput($sformatf("flat_im[%0d]", n), gotIm[n], 0);
        end

        $display("[TB] single tone with backpressure and junk during compute");
        for (int k = 0; k < 8; k++) begin
            frameRe[k] = (k == 1) ? 8192 : 0;
            frameIm[k] = 0;
        end
        runFrame(40, 1, 1, 8);
        for (int t = 0; t < 6; t++) begin
            checkOutput($sformatf("tone_re[%0d]", toneIdx[t]), gotRe[toneIdx[t]], toneRe[t]);
            checkOutput($sformatf("tone_im[%0d]", toneIdx[t]), gotIm[toneIdx[t]], toneIm[t]);
        end

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f < 4) begin
                    frameRe[k] = int'($urandom_range(200000)) - 100000;
                    frameIm[k] = int'($urandom_range(200000)) - 100000;
                end else begin
                    frameRe[k] = $urandom;
                    frameIm[k] = $urandom;
                end
            end
            runFrame(30, f[0], 2, 8);
        end

        $display("[TB] reset during output then DC frame");
        for (int k = 0; k < 8; k++) begin
            frameRe[k] = int'($urandom_range(60000)) - 30000;
            frameIm[k] = int'($urandom_range(60000)) - 30000;
        end
        runFrame(0, 0, 0, 3);
        setDcFrame();
        runFrame(20, 0, 0, 8);
        for (int n = 0; n < 8; n++) begin
            checkOutput($sformatf("post_reset_dc_re[%0d]", n), gotRe[n], 1);
            checkOutput($sformatf("post_reset_dc_im[%0d]", n), gotIm[n], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifft8_seq.md
Name: ifft8_seq

Overview:
- Sequential 8-point inverse FFT. It is the return path for the fft8 forward transform and shares its 32-bit signed sample format.
- Accepts 8 complex frequency bins X[0..7] in natural order over a valid/ready stream.
- Computes x[n] = (1/8)·Σ X[k]·e^{+j2πkn/8} with one time-shared radix-2 DIF butterfly.
- Streams 8 complex time samples out in natural order.

Parameters:
- DW, 32, sample width (signed, two's complement) for input, output and internal storage.
- TW, 16, twiddle width (signed Q1.14; 0.7071 = 11585, 1.0 = 16384).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input bin valid
- in_ready  out  1  block can accept a bin (LOAD state only)
- in_re  in  DW  real part of X[k]
- in_im  in  DW  imaginary part of X[k]
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_re  out  DW  real part of x[n]
- out_im  out  DW  imaginary part of x[n]
- out_last  out  1  high with x[7]
- busy  out  1  high in COMPUTE or OUTPUT

Behaviour:
- Reset (async assert, sync release): state=LOAD, counters=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_re=out_im=0. Working RAM contents are don't-care.
- Handshakes:
  - A transfer occurs on a cycle where valid&&ready.
  - Inputs are captured only on a transfer. The k-th transfer writes RAM[k], k=0..7.
  - out_* holds stable while out_valid && !out_ready.
- FSM LOAD:
  - in_ready=1.
  - After the 8th input transfer, go to COMPUTE on the next cycle. in_ready drops in that same cycle.
- FSM COMPUTE: exactly 12 cycles, 3 stages × 4 butterflies, one butterfly per cycle, computed in place.
  - Stage s=0,1,2 uses span h=4,2,1.
  - Butterfly on pair (i, i+h): a'=a+b; b'=(a−b)·W, with W=e^{+j2π·m/8}.
  - Twiddle index m = (i mod h)·2^s, looked up from a 4-entry ROM:
    - W0 = 16384 + j0
    - W1 = 11585 + j11585
    - W2 = 0 + j16384
    - W3 = −11585 + j11585
  - Multiply rule: full-precision complex product, then >>>14 (arithmetic, floor), then truncate to DW.
  - When W has an exact entry of 1 or j, the result must be identical to a plain swap/negate. Since 16384>>>14 is exact, this holds automatically.
  - Add/sub wrap modulo 2^DW. There is no saturation.
- FSM OUTPUT:
  - Result RAM is in bit-reversed order. The n-th output reads RAM[bitrev3(n)].
  - out_re/out_im = value >>> 3 (the 1/8 scale, floor).
  - out_valid is first asserted on the cycle after the last COMPUTE cycle. That is 13 cycles after the 8th input transfer.
  - Each transfer advances n. out_last=1 while n=7.
  - After the transfer with out_last, go to LOAD next cycle: out_valid=0, in_ready=1.
- Back-to-back frames: no overlap. Input is stalled during COMPUTE and OUTPUT.
- in_valid in COMPUTE/OUTPUT is ignored; there is no capture.
- rst_n low at any point, mid-load or mid-output, aborts the frame immediately. The partial frame is discarded and never emitted.

Decomposition:
- Package ifft8_pkg holds:
  - DW and TW constants
  - the twiddle ROM constants W0..W3
  - the FSM state enum (LOAD, COMPUTE, OUTPUT)
  - the bitrev3 function
- One sub-module, cplx_bfly_dif: combinational a', b' from a, b, W, following the multiply/shift rules above. It is reusable by the forward FFT with conjugated twiddles.

Test Plan:
- DC bin: X=[8,0,0,0,0,0,0,0] (imag 0) -> x[0..7]=1+j0 each. out_last only on the 8th sample. First out_valid exactly 13 cycles after the 8th input transfer.
- Flat spectrum: X[k]=8+j0 for all k -> x[0]=8, x[1..7]=0+j0.
- Single tone: X[1]=8192, all others 0 -> x[0]=1024, x[1]=724+j724, x[2]=j1024, x[4]=−1024, x[6]=−j1024, x[7]=724−j724 (exact values).
- Backpressure: same frame as the single tone, with out_ready toggling 1,0,0,1,… -> identical sample sequence, out_* stable during stalls. in_ready stays 0 until the cycle after out_last is accepted.
- Input gaps and ignore: in_valid deasserted randomly during load -> same results. in_valid=1 with new data during COMPUTE -> not captured, result unchanged.
- Reset mid-frame: assert rst_n=0 during OUTPUT at n=3 -> out_valid=0 and in_ready=1 immediately. A following DC frame yields eight 1+j0 samples.
